barrel_shifter_pipe: RTL
========================

// Module: barrel_shifter_pipe
//
// PURPOSE
//   Pipelined, parametrised barrel shifter. It supports rotate, logical shift and
//   arithmetic shift, with valid/ready flow control and an opaque sideband tag.
//   It is the clocked successor of the 8-bit combinational shifter and sits in
//   the datapath between operand issue and result writeback.
//   Each pipeline stage applies one power-of-two shift, giving log2(WIDTH) stages.
//
// PARAMETERS
//   WIDTH  8  data width in bits; must be a power of 2 and >= 4
//   TAG_W  4  sideband tag width in bits; carried unchanged, data to output
//   AMT_W  $clog2(WIDTH)  localparam: shift-amount width and stage count
//
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      input beat valid
//   in_ready   out  1      block accepts a beat this cycle
//   in_data    in   WIDTH  operand
//   in_amt     in   AMT_W  shift amount, 0..WIDTH-1
//   in_mode    in   3      000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, 101-111 PASS
//   in_tag     in   TAG_W  sideband tag
//   out_valid  out  1      result beat valid
//   out_ready  in   1      downstream accepts the result
//   out_data   out  WIDTH  shifted result
//   out_carry  out  1      last bit shifted out (SLL/SRL/SRA with amt != 0), else 0
//   out_zero   out  1      out_data == 0
//   out_tag    out  TAG_W  tag of this result
//
// BEHAVIOUR
// - Reset:
//   - Every stage valid bit, out_valid, out_data, out_carry, out_zero and out_tag
//     clear to 0. In-flight beats are discarded.
//   - in_ready = 1 in the first cycle after rst_n deasserts.
// - Stages:
//   - Stage k (k = 0..AMT_W-1) shifts by 2^k when amt[k] = 1, then registers the
//     value, mode, amt, tag and carry.
//   - The last stage's registers are the outputs.
//   - Latency is AMT_W cycles from in_valid && in_ready to out_valid, with no stall.
// - Flow control:
//   - Global stall: stall = out_valid && !out_ready.
//   - in_ready = !stall, combinational from out_valid and out_ready.
//   - While stalled, all stage registers hold and outputs stay stable.
//   - Bubbles are not squeezed out.
//   - Throughput is 1 beat per clock when out_ready is held high.
// - Transfers: input on in_valid && in_ready; output on out_valid && out_ready.
//   Beats leave in acceptance order.
// - Mode rules:
//   - ROL/ROR: bits wrap around. out_carry = 0.
//   - SLL/SRL: zero fill.
//   - SRA: the data MSB at stage 0 fills vacated MSBs.
//     Example: 0x80 >> 7 = 0xFF.
//   - PASS (101-111): out_data = in_data, out_carry = 0. amt is ignored.
// - Carry:
//   - A stage with a nonzero shift s overwrites the carry with the bit it shifts
//     out last: cur[WIDTH-s] for left shifts, cur[s-1] for right shifts.
//   - A zero-shift stage keeps the carry. The carry starts at 0.
//   - Net result: SLL gives orig[WIDTH-amt]; SRL/SRA give orig[amt-1].
// - amt = 0: out_data = in_data and out_carry = 0 in every mode.
// - out_zero is registered together with out_data. It is never stale relative
//   to out_data.
// - Reset asserted mid-stream: outputs clear immediately (async). No partial
//   beat is emitted after release.
// - in_data, in_amt, in_mode and in_tag are don't-care when in_valid = 0.
//   Stage valid bits still shift in a 0.
//
// TESTING  (WIDTH=8, latency 3)
// - ROL 0x55 for amt 0..7, out_ready=1 -> 0x55,0xAA,0x55,...
//   One result per clock, each 3 cycles after its input. out_carry=0.
// - SLL 0xCC amt 2 -> 0x30, carry 1.
//   SRL 0x01 amt 1 -> 0x00, zero 1, carry 1.
//   SRA 0x80 amt 3 -> 0xF0, carry 0.
// - SRA 0x7F amt 7 -> 0x00, carry 1.
//   SRA 0x80 amt 7 -> 0xFF.
//   PASS (mode 101) 0xA5 amt 5 -> 0xA5, carry 0.
// - Stream 8 beats with tags 0..7 and drop out_ready for 5 cycles mid-stream:
//   - in_ready low exactly while out_valid && !out_ready.
//   - out_data stable while stalled.
//   - All 8 results arrive in tag order, none lost or duplicated.
// - Random mode, amt, data and tag, with random in_valid/out_ready, 10k beats:
//   match the reference model, including carry and zero.
// - Assert rst_n low for 1 cycle with 3 beats in flight:
//   - out_valid=0 and outputs 0 immediately.
//   - No stale beat appears after release.
//   - The next accepted beat emerges after 3 cycles.

Source files
------------

// File: rtl/barrel_shifter_pipe_if.sv
// Operand/result bus of the pipelined barrel shifter.
//   in_valid/in_ready  : operand handshake (issue side)
//   in_data            : operand, WIDTH bits
//   in_amt             : shift amount, AMT_W bits
//   in_mode            : 000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, others PASS
//   in_tag             : opaque sideband tag, TAG_W bits
//   out_valid/out_ready: result handshake (writeback side)
//   out_data/out_carry/out_zero/out_tag: result beat
// master = the block driving operands and accepting results; slave = the shifter.
interface barrel_shifter_pipe_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_tag
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: rotate, logical shift and arithmetic shift.
// Stage k shifts by 2^k when amt[k] is set, so there are log2(WIDTH) stages and
// the last stage's registers drive the result bus directly.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every stage and the outputs
//   bus   : barrel_shifter_pipe_if.slave (operand in, result out, valid/ready)
// Flow control is a global stall: when the output beat is not taken, every
// stage holds; bubbles stay in the pipe.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  barrel_shifter_pipe_if.slave   bus
);
  localparam int AMT_W = $clog2(WIDTH);
  localparam int LAST  = AMT_W - 1;

  localparam logic [2:0] MODE_ROL = 3'b000;
  localparam logic [2:0] MODE_ROR = 3'b001;
  localparam logic [2:0] MODE_SLL = 3'b010;
  localparam logic [2:0] MODE_SRL = 3'b011;
  localparam logic [2:0] MODE_SRA = 3'b100;

  // One stage: shift by 2^k if enabled. Returns {carry, data}. A shifting
  // stage overwrites the carry with the last bit it pushes out; rotates never
  // touch it, so it stays at its initial 0.
  function automatic logic [WIDTH:0] stage_shift(
    input logic [WIDTH-1:0] cur,
    input logic [2:0]       mode,
    input logic             carry_in,
    input logic             en,
    input int               k
  );
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] one;
    logic [WIDTH-1:0] mask_l;
    logic [WIDTH-1:0] mask_r;
    logic             c;
    int               s;
    s      = 1 << k;
    one    = {{(WIDTH-1){1'b0}}, 1'b1};
    mask_l = one << (WIDTH - s);  // selects cur[WIDTH-s]
    mask_r = one << (s - 1);      // selects cur[s-1]
    res    = cur;
    c      = carry_in;
    if (en) begin
      case (mode)
        MODE_ROL: res = (cur << s) | (cur >> (WIDTH - s));
        MODE_ROR: res = (cur >> s) | (cur << (WIDTH - s));
        MODE_SLL: begin
          res = cur << s;
          c   = |(cur & mask_l);
        end
        MODE_SRL: begin
          res = cur >> s;
          c   = |(cur & mask_r);
        end
        MODE_SRA: begin
          // MSB is preserved by each arithmetic stage, so filling from the
          // current MSB equals filling from the operand MSB.
          res = $signed(cur) >>> s;
          c   = |(cur & mask_r);
        end
        default: ;
      endcase
    end
    return {c, res};
  endfunction

  // Stage registers, index k = stage k (_p0.._p{LAST})
  logic [AMT_W-1:0] r_vld_p;
  logic [WIDTH-1:0] r_data_p  [AMT_W];
  logic [2:0]       r_mode_p  [AMT_W];
  logic [AMT_W-1:0] r_amt_p   [AMT_W];
  logic [TAG_W-1:0] r_tag_p   [AMT_W];
  logic [AMT_W-1:0] r_carry_p;
  logic             r_zero;

  // Stage inputs (bus for stage 0, previous stage otherwise) and results
  logic [AMT_W-1:0] w_src_vld;
  logic [WIDTH-1:0] w_src_data  [AMT_W];
  logic [2:0]       w_src_mode  [AMT_W];
  logic [AMT_W-1:0] w_src_amt   [AMT_W];
  logic [TAG_W-1:0] w_src_tag   [AMT_W];
  logic [AMT_W-1:0] w_src_carry;
  logic [WIDTH-1:0] w_nxt_data  [AMT_W];
  logic [AMT_W-1:0] w_nxt_carry;
  logic             w_stall;

  assign w_stall       = r_vld_p[LAST] && !bus.out_ready;
  assign bus.in_ready  = !w_stall;
  assign bus.out_valid = r_vld_p[LAST];
  assign bus.out_data  = r_data_p[LAST];
  assign bus.out_carry = r_carry_p[LAST];
  assign bus.out_zero  = r_zero;
  assign bus.out_tag   = r_tag_p[LAST];

  always_comb begin
    w_src_vld      = '0;
    w_src_carry    = '0;
    w_nxt_carry    = '0;
    w_src_vld[0]   = bus.in_valid;
    w_src_data[0]  = bus.in_data;
    w_src_mode[0]  = bus.in_mode;
    w_src_amt[0]   = bus.in_amt;
    w_src_tag[0]   = bus.in_tag;
    for (int k = 1; k < AMT_W; k++) begin
      w_src_vld[k]   = r_vld_p[k-1];
      w_src_data[k]  = r_data_p[k-1];
      w_src_mode[k]  = r_mode_p[k-1];
      w_src_amt[k]   = r_amt_p[k-1];
      w_src_tag[k]   = r_tag_p[k-1];
      w_src_carry[k] = r_carry_p[k-1];
    end
    for (int k = 0; k < AMT_W; k++) begin
      {w_nxt_carry[k], w_nxt_data[k]} = stage_shift(w_src_data[k], w_src_mode[k],
                                                    w_src_carry[k], w_src_amt[k][k], k);
    end
  end

  // ---- stage boundary: all stages advance together unless stalled ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p   <= '0;
      r_carry_p <= '0;
      r_zero    <= 1'b0;
      for (int k = 0; k < AMT_W; k++) begin
        r_data_p[k] <= '0;
        r_mode_p[k] <= '0;
        r_amt_p[k]  <= '0;
        r_tag_p[k]  <= '0;
      end
    end else if (!w_stall) begin
      r_vld_p   <= w_src_vld;
      r_carry_p <= w_nxt_carry;
      // zero flag is computed from the same value loaded into the output stage
      r_zero    <= (w_nxt_data[LAST] == '0);
      for (int k = 0; k < AMT_W; k++) begin
        r_data_p[k] <= w_nxt_data[k];
        r_mode_p[k] <= w_src_mode[k];
        r_amt_p[k]  <= w_src_amt[k];
        r_tag_p[k]  <= w_src_tag[k];
      end
    end
  end

endmodule
